// File: rtl/imm_extender_pkg.sv
// Immediate extender shared types: extension modes and the width-generic
// extend() function used at input acceptance.
package imm_ext_pkg;

   localparam int MODE_W = 2;
   localparam int MAX_W  = 64;

   typedef enum logic [MODE_W-1:0] {
      MODE_ZERO  = 2'd0,
      MODE_SIGN  = 2'd1,
      MODE_SHL   = 2'd2,
      MODE_UPPER = 2'd3
   } mode_t;

   // Widths travel as arguments so one function serves every instance; the
   // caller passes elaboration constants and keeps only the low out_w bits.
   function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] imm,
                                                input mode_t            mode,
                                                input int               in_w,
                                                input int               out_w,
                                                input int               shift);
      logic [MAX_W-1:0] in_mask;
      logic [MAX_W-1:0] out_mask;
      logic [MAX_W-1:0] zext;
      logic [MAX_W-1:0] sext;
      logic [MAX_W-1:0] res;
      logic             sgn;
      in_mask  = (64'd1 << in_w) - 64'd1;
      out_mask = (64'd1 << out_w) - 64'd1;
      zext     = imm & in_mask;
      sgn      = ((zext >> (in_w - 1)) & 64'd1) != 64'd0;
      sext     = sgn ? (zext | ~in_mask) : zext;
      case (mode)
         MODE_ZERO:  res = zext;
         MODE_SIGN:  res = sext;
         MODE_SHL:   res = sext << shift;
         MODE_UPPER: res = zext << (out_w - in_w);
         default:    res = zext;
      endcase
      return res & out_mask;
   endfunction

endpackage

// File: rtl/imm_extender_if.sv
// Handshake bundle between decode, the immediate extender and the ALU mux.
// slave = the extender, master = the surrounding producer/consumer.
interface imm_extender_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 16
);
   import imm_ext_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   mode_t            in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   mode_t            out_mode;

   modport slave (
      input  in_valid, in_imm, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_mode
   );

   modport master (
      output in_valid, in_imm, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_mode
   );
endinterface

// File: rtl/imm_extender_elastic_skid.sv
// Generic valid/ready register stage.
// IMM_EXT_SKID_EN defined: main + skid register, in_ready is a flop output
// (no combinational out_ready -> in_ready path).
// Undefined: single register, in_ready = !out_valid || out_ready.
module elastic_skid #(
   parameter int WIDTH = 18
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

`ifdef IMM_EXT_SKID_EN
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;

   assign in_ready = !skid_valid;

   // main refills from skid first so ordering stays FIFO; skid only catches
   // a beat arriving while main is full and stalled
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
         end
      end else if (in_valid && !skid_valid) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end
`else
   assign in_ready = !out_valid || out_ready;

   // single holding register, reloaded whenever it is empty or being consumed
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end
`endif

endmodule

// File: rtl/imm_extender.sv
// Pipelined immediate extender: extend() applied on the input side, result
// plus mode carried through elastic_skid. Optional skid stage selected with
// the IMM_EXT_SKID_EN macro.
module imm_extender
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int OUT_W = 16,
   parameter int SHIFT = 1
) (
   input  logic         CLK,
   input  logic         RST_N,
   imm_extender_if.slave bus
);

   localparam int PW = OUT_W + MODE_W;

   if (IN_W < 1 || OUT_W <= IN_W || OUT_W >= MAX_W || SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_params
      $error("imm_extender: illegal IN_W/OUT_W/SHIFT combination");
   end

   logic [MAX_W-1:0]  imm_wide;
   logic [MAX_W-1:0]  ext_wide;
   logic [OUT_W-1:0]  ext_data;
   logic [MODE_W-1:0] in_mode_bits;
   logic [PW-1:0]     stage_out;
   logic              unused_ext_hi;

   // computed before the register so the stored value never changes later
   assign imm_wide      = MAX_W'(bus.in_imm);
   assign ext_wide      = extend(imm_wide, bus.in_mode, IN_W, OUT_W, SHIFT);
   assign ext_data      = ext_wide[OUT_W-1:0];
   assign unused_ext_hi = ^ext_wide[MAX_W-1:OUT_W];
   assign in_mode_bits  = bus.in_mode;

   elastic_skid #(.WIDTH(PW)) u_stage (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   ({in_mode_bits, ext_data}),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (stage_out)
   );

   assign bus.out_data = stage_out[OUT_W-1:0];
   assign bus.out_mode = mode_t'(stage_out[PW-1:OUT_W]);

endmodule

// File: tb/tb_imm_extender.sv
// Bench for imm_extender: 8->16 (SHIFT=1) instance with scoreboard and
// directed sequences, plus a 12->32 (SHIFT=2) instance for width corners.
module tb_imm_extender;
   import imm_ext_pkg::*;

`ifdef IMM_EXT_SKID_EN
   localparam int EXP_ACC = 2;
   localparam bit SKID    = 1'b1;
`else
   localparam int EXP_ACC = 1;
   localparam bit SKID    = 1'b0;
`endif

   logic CLK;
   logic RST_N;
   int   checks;
   int   errors;

   imm_extender_if #(.IN_W(8),  .OUT_W(16)) b ();
   imm_extender_if #(.IN_W(12), .OUT_W(32)) w ();

   imm_extender #(.IN_W(8),  .OUT_W(16), .SHIFT(1)) dut   (.CLK(CLK), .RST_N(RST_N), .bus(b.slave));
   imm_extender #(.IN_W(12), .OUT_W(32), .SHIFT(2)) dut_w (.CLK(CLK), .RST_N(RST_N), .bus(w.slave));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      bit          wide;
      logic [11:0] imm;
      logic [1:0]  mode;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[14];
   logic [17:0] sbq[$];
   logic [15:0] got[$];
   bit          held;
   logic [17:0] held_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: integer arithmetic on the immediate's numeric value.
   function automatic longint ref_ext(int imm, int mode, int in_w, int out_w, int sh);
      longint mag, span, sval, modulus, r;
      mag     = longint'(imm);
      span    = longint'(1) << in_w;
      sval    = (mag >= span / 2) ? mag - span : mag;
      modulus = longint'(1) << out_w;
      case (mode)
         0:       r = mag;
         1:       r = sval;
         2:       r = sval * (longint'(1) << sh);
         default: r = mag * (longint'(1) << (out_w - in_w));
      endcase
      r = r % modulus;
      if (r < 0) r = r + modulus;
      return r;
   endfunction

   // Scoreboard for the narrow instance, sampled at negedge.
   task automatic monitor();
      logic [17:0] e;
      if (!RST_N) begin
         sbq.delete();
         held = 1'b0;
         return;
      end
      if (held) begin
         check("hold_valid", 32'(b.out_valid), 32'd1);
         check("hold_data", 32'({b.out_mode, b.out_data}), 32'(held_val));
      end
      if (b.out_valid && b.out_ready) begin
         if (sbq.size() == 0) begin
            check("sb_unexpected_beat", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            check("sb_data", 32'(b.out_data), 32'(e[15:0]));
            check("sb_mode", 32'(b.out_mode), 32'(e[17:16]));
         end
      end
      held     = b.out_valid && !b.out_ready;
      held_val = {b.out_mode, b.out_data};
      if (b.in_valid && b.in_ready)
         sbq.push_back({2'(b.in_mode), 16'(ref_ext(int'(b.in_imm), int'(b.in_mode), 8, 16, 1))});
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int  acc;
      int  idx;
      bit  fire;
      bit  last_fire;

      checks   = 0;
      errors   = 0;
      held     = 1'b0;
      held_val = '0;
      RST_N    = 1'b0;
      b.in_valid = 1'b0; b.in_imm = '0; b.in_mode = MODE_ZERO; b.out_ready = 1'b1;
      w.in_valid = 1'b0; w.in_imm = '0; w.in_mode = MODE_ZERO; w.out_ready = 1'b1;

      vecs[0]  = '{1'b0, 12'h085, 2'd0, 32'h0000_0085};
      vecs[1]  = '{1'b0, 12'h085, 2'd1, 32'h0000_FF85};
      vecs[2]  = '{1'b0, 12'h085, 2'd2, 32'h0000_FF0A};
      vecs[3]  = '{1'b0, 12'h085, 2'd3, 32'h0000_8500};
      vecs[4]  = '{1'b0, 12'h07F, 2'd1, 32'h0000_007F};
      vecs[5]  = '{1'b0, 12'h07F, 2'd2, 32'h0000_00FE};
      vecs[6]  = '{1'b0, 12'h080, 2'd2, 32'h0000_FF00};
      vecs[7]  = '{1'b0, 12'h0FF, 2'd3, 32'h0000_FF00};
      vecs[8]  = '{1'b0, 12'h000, 2'd1, 32'h0000_0000};
      vecs[9]  = '{1'b1, 12'h800, 2'd2, 32'hFFFF_E000};
      vecs[10] = '{1'b1, 12'hABC, 2'd3, 32'hABC0_0000};
      vecs[11] = '{1'b1, 12'hABC, 2'd1, 32'hFFFF_FABC};
      vecs[12] = '{1'b1, 12'h7FF, 2'd2, 32'h0000_1FFC};
      vecs[13] = '{1'b1, 12'h800, 2'd0, 32'h0000_0800};

      fork
         forever begin
            @(negedge CLK);
            monitor();
         end
      join_none

      // reset values
      #2;
      check("rst_out_valid", 32'(b.out_valid), 32'd0);
      check("rst_out_data", 32'(b.out_data), 32'd0);
      check("rst_out_mode", 32'(b.out_mode), 32'd0);
      tick();
      tick();
      RST_N = 1'b1;
      tick();
      check("rst_in_ready", 32'(b.in_ready), 32'd1);

      // mode table, one beat at a time, result expected one edge after accept
      foreach (vecs[i]) begin
         if (vecs[i].wide) begin
            w.in_valid = 1'b1; w.in_imm = vecs[i].imm; w.in_mode = mode_t'(vecs[i].mode);
         end else begin
            b.in_valid = 1'b1; b.in_imm = vecs[i].imm[7:0]; b.in_mode = mode_t'(vecs[i].mode);
         end
         tick();
         b.in_valid = 1'b0;
         w.in_valid = 1'b0;
         if (vecs[i].wide) begin
            check($sformatf("vec%0d_valid", i), 32'(w.out_valid), 32'd1);
            check($sformatf("vec%0d_data", i), w.out_data, vecs[i].exp);
            check($sformatf("vec%0d_mode", i), 32'(w.out_mode), 32'(vecs[i].mode));
         end else begin
            check($sformatf("vec%0d_valid", i), 32'(b.out_valid), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(b.out_data), vecs[i].exp);
            check($sformatf("vec%0d_mode", i), 32'(b.out_mode), 32'(vecs[i].mode));
         end
      end
      tick();
      check("idle_valid", 32'(b.out_valid), 32'd0);

      // streaming: 16 back-to-back sign-extended beats, no bubbles
      b.in_valid = 1'b1; b.in_mode = MODE_SIGN; b.in_imm = 8'h00;
      for (int i = 0; i < 16; i++) begin
         tick();
         check($sformatf("stream%0d_valid", i), 32'(b.out_valid), 32'd1);
         check($sformatf("stream%0d_data", i), 32'(b.out_data), 32'(i));
         if (i < 15) b.in_imm = 8'(i + 1);
         else        b.in_valid = 1'b0;
      end
      tick();
      check("stream_valid_fall", 32'(b.out_valid), 32'd0);

      // backpressure: 4 stalled cycles offering 0x01,0x02,0x03
      b.out_ready = 1'b0; b.in_valid = 1'b1; b.in_mode = MODE_SIGN; b.in_imm = 8'h01;
      acc = 0; idx = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         fire = b.in_valid && b.in_ready;
         tick();
         if (fire) begin
            acc++; idx++;
            if (idx == 3) b.in_valid = 1'b0;
            else          b.in_imm = 8'(idx + 1);
         end
      end
      check("bp_accepted", 32'(acc), 32'(EXP_ACC));
      check("bp_in_ready_stalled", 32'(b.in_ready), 32'd0);
      b.out_ready = 1'b1;
      #1;
      check("bp_in_ready_comb", 32'(b.in_ready), SKID ? 32'd0 : 32'd1);
      got.delete();
      for (int c = 0; c < 20 && got.size() < 3; c++) begin
         @(negedge CLK);
         fire = b.in_valid && b.in_ready;
         if (b.out_valid && b.out_ready) got.push_back(b.out_data);
         tick();
         if (fire) begin
            acc++; idx++;
            if (idx == 3) b.in_valid = 1'b0;
            else          b.in_imm = 8'(idx + 1);
         end
      end
      check("bp_total_accepted", 32'(acc), 32'd3);
      check("bp_out_count", 32'(got.size()), 32'd3);
      for (int i = 0; i < 3 && i < got.size(); i++)
         check($sformatf("bp_out%0d", i), 32'(got[i]), 32'(i + 1));
      b.in_valid = 1'b0;
      tick();
      tick();

      // async reset in the middle of a stall with beats buffered
      b.out_ready = 1'b0; b.in_valid = 1'b1; b.in_imm = 8'h55; b.in_mode = MODE_UPPER;
      tick(); tick(); tick();
      check("pre_rst_valid", 32'(b.out_valid), 32'd1);
      b.in_valid = 1'b0;
      RST_N = 1'b0;
      #1;
      check("midrst_out_valid", 32'(b.out_valid), 32'd0);
      check("midrst_out_data", 32'(b.out_data), 32'd0);
      check("midrst_out_mode", 32'(b.out_mode), 32'd0);
      tick();
      RST_N = 1'b1;
      b.out_ready = 1'b1;
      tick();
      check("postrst_in_ready", 32'(b.in_ready), 32'd1);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("postrst_no_stale%0d", c), 32'(b.out_valid), 32'd0);
         tick();
      end

      // randomized traffic against the scoreboard, producer holds while stalled
      last_fire = 1'b1;
      for (int c = 0; c < 500; c++) begin
         if (!(b.in_valid && !last_fire)) begin
            b.in_valid = ($urandom_range(0, 3) != 0);
            b.in_imm   = 8'($urandom_range(0, 255));
            b.in_mode  = mode_t'($urandom_range(0, 3));
         end
         b.out_ready = ($urandom_range(0, 2) != 0);
         @(negedge CLK);
         last_fire = b.in_valid && b.in_ready;
         tick();
      end
      b.in_valid  = 1'b0;
      b.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      check("drain_out_valid", 32'(b.out_valid), 32'd0);
      check("drain_sb_empty", 32'(sbq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
